// File: rtl/psu_sweep_ctrl_pkg.sv
// Shared types and default sizing for the PSU nested-loop sweeper.
package psu_sweep_ctrl_pkg;

  localparam int unsigned DefNumQbctrl = 4;
  localparam int unsigned DefNumUcc    = 2;
  localparam int unsigned DefQbaddrBw  = 5;
  localparam int unsigned DefUcaddrBw  = 3;
  localparam int unsigned DefIdlenBw   = 4;
  localparam int unsigned DefRoundBw   = 3;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StWait = 2'd2
  } psu_state_e;

  // A loop bound of zero would never terminate, so it runs a single pass instead.
  function automatic int unsigned at_least_one(int unsigned v);
    return (v == 0) ? 1 : v;
  endfunction

endpackage

// File: rtl/psu_sweep_ctrl_if.sv
// Sweeper control/status bundle. PSU_SWEEP_PERF_EN adds the performance counter outputs.
interface psu_sweep_ctrl_if
  import psu_sweep_ctrl_pkg::*;
#(
  parameter int unsigned NUM_QBCTRL = DefNumQbctrl,
  parameter int unsigned NUM_UCC    = DefNumUcc,
  parameter int unsigned QBADDR_BW  = DefQbaddrBw,
  parameter int unsigned UCADDR_BW  = DefUcaddrBw,
  parameter int unsigned IDLEN_BW   = DefIdlenBw,
  parameter int unsigned ROUND_BW   = DefRoundBw
);
  logic                              start;
  logic [QBADDR_BW-1:0]              qb_limit;
  logic [UCADDR_BW-1:0]              uc_limit;
  logic [IDLEN_BW-1:0]               id_len;
  logic [ROUND_BW-1:0]               round_len;
  logic                              pch_avail;
  logic                              pch_last;
  logic                              stall;
  logic [NUM_QBCTRL*QBADDR_BW-1:0]   qb_counter;
  logic [NUM_UCC*UCADDR_BW-1:0]      uc_counter;
  logic [IDLEN_BW-1:0]               id_counter;
  logic [ROUND_BW-1:0]               round_counter;
  logic                              step_valid;
  logic                              next_pch;
  logic                              next_id;
  logic                              next_round;
  logic                              next_opcode;
  logic                              busy;
`ifdef PSU_SWEEP_PERF_EN
  logic [31:0]                       perf_stall_cnt;
  logic [31:0]                       perf_wait_cnt;
  logic [31:0]                       perf_step_cnt;

  modport master (
    output start, qb_limit, uc_limit, id_len, round_len, pch_avail, pch_last, stall,
    input  qb_counter, uc_counter, id_counter, round_counter, step_valid, next_pch,
    input  next_id, next_round, next_opcode, busy,
    input  perf_stall_cnt, perf_wait_cnt, perf_step_cnt
  );
  modport slave (
    input  start, qb_limit, uc_limit, id_len, round_len, pch_avail, pch_last, stall,
    output qb_counter, uc_counter, id_counter, round_counter, step_valid, next_pch,
    output next_id, next_round, next_opcode, busy,
    output perf_stall_cnt, perf_wait_cnt, perf_step_cnt
  );
`else
  modport master (
    output start, qb_limit, uc_limit, id_len, round_len, pch_avail, pch_last, stall,
    input  qb_counter, uc_counter, id_counter, round_counter, step_valid, next_pch,
    input  next_id, next_round, next_opcode, busy
  );
  modport slave (
    input  start, qb_limit, uc_limit, id_len, round_len, pch_avail, pch_last, stall,
    output qb_counter, uc_counter, id_counter, round_counter, step_valid, next_pch,
    output next_id, next_round, next_opcode, busy
  );
`endif
endinterface

// File: rtl/psu_lane_cnt.sv
// Strided lane address counter: lane k = base + k, base steps by NUM_LANE on adv, returns to 0 on clr.
module psu_lane_cnt #(
  parameter int unsigned NUM_LANE = 4,
  parameter int unsigned ADDR_BW  = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        adv,
  input  logic                        clr,
  output logic [ADDR_BW-1:0]          base,
  output logic [NUM_LANE*ADDR_BW-1:0] lanes
);

  logic [ADDR_BW-1:0] base_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      base_q <= '0;
    end else if (adv) begin
      base_q <= base_q + ADDR_BW'(NUM_LANE);
    end
  end

  always_comb begin
    lanes = '0;
    for (int unsigned k = 0; k < NUM_LANE; k++) begin
      lanes[k*ADDR_BW +: ADDR_BW] = base_q + ADDR_BW'(k);
    end
  end

  assign base = base_q;

endmodule

// File: rtl/psu_sweep_ctrl.sv
// Nested-loop PSU sweeper: qb lanes innermost, then uc lanes, pchinfo entries, ids and rounds.
// PSU_SWEEP_PERF_EN adds saturating stall/wait/step cycle counters.
module psu_sweep_ctrl
  import psu_sweep_ctrl_pkg::*;
#(
  parameter int unsigned NUM_QBCTRL = DefNumQbctrl,
  parameter int unsigned NUM_UCC    = DefNumUcc,
  parameter int unsigned QBADDR_BW  = DefQbaddrBw,
  parameter int unsigned UCADDR_BW  = DefUcaddrBw,
  parameter int unsigned IDLEN_BW   = DefIdlenBw,
  parameter int unsigned ROUND_BW   = DefRoundBw
) (
  input logic             clk,
  input logic             rst,
  psu_sweep_ctrl_if.slave bus
);

  localparam int unsigned QbSumBw = QBADDR_BW + 1;
  localparam int unsigned UcSumBw = UCADDR_BW + 1;

  psu_state_e state_q, state_d;

  logic [QBADDR_BW-1:0] qb_lim_q;
  logic [UCADDR_BW-1:0] uc_lim_q;
  logic [IDLEN_BW-1:0]  id_lim_q;
  logic [ROUND_BW-1:0]  round_lim_q;
  logic [IDLEN_BW-1:0]  id_q;
  logic [ROUND_BW-1:0]  round_q;

  logic [QBADDR_BW-1:0] qb_base;
  logic [UCADDR_BW-1:0] uc_base;
  logic                 qb_wrap, uc_wrap;
  logic                 step_valid, next_pch, next_id, next_round, next_opcode;
  logic                 start_ok;

  // Wrap compares are done one bit wider so a base near the top of its field cannot alias.
  assign qb_wrap = ({1'b0, qb_base} + QbSumBw'(NUM_QBCTRL)) >= {1'b0, qb_lim_q};
  assign uc_wrap = ({1'b0, uc_base} + UcSumBw'(NUM_UCC)) >= {1'b0, uc_lim_q};

  assign start_ok = (state_q == StIdle) && bus.start && !bus.stall;

  always_comb begin
    state_d     = state_q;
    step_valid  = 1'b0;
    next_pch    = 1'b0;
    next_id     = 1'b0;
    next_round  = 1'b0;
    next_opcode = 1'b0;

    // Strobes are suppressed during reset so nothing is popped from a half-finished sweep.
    step_valid  = (state_q == StRun) && bus.pch_avail && !bus.stall && !rst;
    next_pch    = step_valid && qb_wrap && uc_wrap;
    next_id     = next_pch && bus.pch_last;
    next_round  = next_id && (id_q == id_lim_q - IDLEN_BW'(1));
    next_opcode = next_round && (round_q == round_lim_q - ROUND_BW'(1));

    case (state_q)
      StIdle: if (start_ok) state_d = StRun;
      StRun: begin
        if (next_opcode) begin
          state_d = StIdle;
        end else if (!bus.pch_avail && !bus.stall) begin
          state_d = StWait;
        end
      end
      StWait: if (bus.pch_avail && !bus.stall) state_d = StRun;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      qb_lim_q    <= QBADDR_BW'(1);
      uc_lim_q    <= UCADDR_BW'(1);
      id_lim_q    <= IDLEN_BW'(1);
      round_lim_q <= ROUND_BW'(1);
      id_q        <= '0;
      round_q     <= '0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        qb_lim_q    <= QBADDR_BW'(at_least_one(32'(bus.qb_limit)));
        uc_lim_q    <= UCADDR_BW'(at_least_one(32'(bus.uc_limit)));
        id_lim_q    <= IDLEN_BW'(at_least_one(32'(bus.id_len)));
        round_lim_q <= ROUND_BW'(at_least_one(32'(bus.round_len)));
      end
      if (next_round) begin
        id_q <= '0;
      end else if (next_id) begin
        id_q <= id_q + IDLEN_BW'(1);
      end
      if (next_opcode) begin
        round_q <= '0;
      end else if (next_round) begin
        round_q <= round_q + ROUND_BW'(1);
      end
    end
  end

  psu_lane_cnt #(
    .NUM_LANE (NUM_QBCTRL),
    .ADDR_BW  (QBADDR_BW)
  ) u_qb_cnt (
    .clk   (clk),
    .rst   (rst),
    .adv   (step_valid && !qb_wrap),
    .clr   (step_valid && qb_wrap),
    .base  (qb_base),
    .lanes (bus.qb_counter)
  );

  psu_lane_cnt #(
    .NUM_LANE (NUM_UCC),
    .ADDR_BW  (UCADDR_BW)
  ) u_uc_cnt (
    .clk   (clk),
    .rst   (rst),
    .adv   (step_valid && qb_wrap && !uc_wrap),
    .clr   (next_pch),
    .base  (uc_base),
    .lanes (bus.uc_counter)
  );

  assign bus.id_counter    = id_q;
  assign bus.round_counter = round_q;
  assign bus.step_valid    = step_valid;
  assign bus.next_pch      = next_pch;
  assign bus.next_id       = next_id;
  assign bus.next_round    = next_round;
  assign bus.next_opcode   = next_opcode;
  assign bus.busy          = (state_q != StIdle);

`ifdef PSU_SWEEP_PERF_EN
  logic [31:0] perf_stall_q, perf_wait_q, perf_step_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_wait_q  <= '0;
      perf_step_q  <= '0;
    end else begin
      if ((state_q != StIdle) && bus.stall && (perf_stall_q != '1)) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
      if ((state_q == StWait) && (perf_wait_q != '1)) begin
        perf_wait_q <= perf_wait_q + 32'd1;
      end
      if (step_valid && (perf_step_q != '1)) begin
        perf_step_q <= perf_step_q + 32'd1;
      end
    end
  end

  assign bus.perf_stall_cnt = perf_stall_q;
  assign bus.perf_wait_cnt  = perf_wait_q;
  assign bus.perf_step_cnt  = perf_step_q;
`endif

endmodule

// File: tb/tb_psu_sweep_ctrl.sv
// Directed vector bench for psu_sweep_ctrl: a per-cycle table plus a hand-written reset sequence.
module tb_psu_sweep_ctrl;

  localparam int unsigned NQ  = 4;
  localparam int unsigned NU  = 2;
  localparam int unsigned QBW = 5;
  localparam int unsigned UBW = 3;
  localparam int unsigned IBW = 4;
  localparam int unsigned RBW = 3;

  // Flag order: {busy, step_valid, next_pch, next_id, next_round, next_opcode}
  localparam logic [5:0] FIdle = 6'b000000;
  localparam logic [5:0] FBusy = 6'b100000;
  localparam logic [5:0] FStep = 6'b110000;
  localparam logic [5:0] FPch  = 6'b111000;
  localparam logic [5:0] FId   = 6'b111100;
  localparam logic [5:0] FRnd  = 6'b111110;
  localparam logic [5:0] FOpc  = 6'b111111;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  psu_sweep_ctrl_if #(
    .NUM_QBCTRL (NQ), .NUM_UCC (NU), .QBADDR_BW (QBW),
    .UCADDR_BW  (UBW), .IDLEN_BW (IBW), .ROUND_BW (RBW)
  ) bus ();

  psu_sweep_ctrl #(
    .NUM_QBCTRL (NQ), .NUM_UCC (NU), .QBADDR_BW (QBW),
    .UCADDR_BW  (UBW), .IDLEN_BW (IBW), .ROUND_BW (RBW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [QBW-1:0] qbl;
    logic [UBW-1:0] ucl;
    logic [IBW-1:0] idl;
    logic [RBW-1:0] rl;
    logic           start, stall, avail, last;
    logic [QBW-1:0] qb0;
    logic [UBW-1:0] uc0;
    logic [IBW-1:0] id;
    logic [RBW-1:0] rnd;
    logic [5:0]     flags;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cq, cu, ci, cr;

  function automatic void cfg(int q, int u, int i, int r);
    cq = q; cu = u; ci = i; cr = r;
  endfunction

  function automatic void add(logic st, logic sl, logic av, logic la,
                              int qb0, int uc0, int id, int rnd, logic [5:0] fl);
    vec_t v;
    v.qbl = QBW'(cq); v.ucl = UBW'(cu); v.idl = IBW'(ci); v.rl = RBW'(cr);
    v.start = st; v.stall = sl; v.avail = av; v.last = la;
    v.qb0 = QBW'(qb0); v.uc0 = UBW'(uc0); v.id = IBW'(id); v.rnd = RBW'(rnd);
    v.flags = fl;
    vecs.push_back(v);
  endfunction

  function automatic logic [NQ*QBW-1:0] qb_flat(logic [QBW-1:0] b);
    logic [NQ*QBW-1:0] r;
    for (int k = 0; k < NQ; k++) r[k*QBW +: QBW] = b + QBW'(k);
    return r;
  endfunction

  function automatic logic [NU*UBW-1:0] uc_flat(logic [UBW-1:0] b);
    logic [NU*UBW-1:0] r;
    for (int k = 0; k < NU; k++) r[k*UBW +: UBW] = b + UBW'(k);
    return r;
  endfunction

  task automatic chk(string nm, int idx, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", nm, idx, act, exp);
    end
  endtask

  function automatic logic [5:0] dut_flags();
    return {bus.busy, bus.step_valid, bus.next_pch, bus.next_id, bus.next_round,
            bus.next_opcode};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    bus.start = 1'b0; bus.stall = 1'b0; bus.pch_avail = 1'b0; bus.pch_last = 1'b0;
    bus.qb_limit = '0; bus.uc_limit = '0; bus.id_len = '0; bus.round_len = '0;

    // Test 1: 8/4/2/1, start while busy (other limits) and start on next_opcode ignored
    cfg(8, 4, 2, 1);
    add(1, 0, 1, 1, 0, 0, 0, 0, FIdle);
    add(0, 0, 1, 1, 0, 0, 0, 0, FStep);
    add(0, 0, 1, 1, 4, 0, 0, 0, FStep);
    cfg(4, 2, 1, 1);
    add(1, 0, 1, 1, 0, 2, 0, 0, FStep);
    cfg(8, 4, 2, 1);
    add(0, 0, 1, 1, 4, 2, 0, 0, FId);
    add(0, 0, 1, 1, 0, 0, 1, 0, FStep);
    add(0, 0, 1, 1, 4, 0, 1, 0, FStep);
    add(0, 0, 1, 1, 0, 2, 1, 0, FStep);
    add(1, 0, 1, 1, 4, 2, 1, 0, FOpc);
    // Test 2: minimum gap restart, 3-cycle stall at step 3
    add(1, 0, 1, 1, 0, 0, 0, 0, FIdle);
    add(0, 0, 1, 1, 0, 0, 0, 0, FStep);
    add(0, 0, 1, 1, 4, 0, 0, 0, FStep);
    for (int i = 0; i < 3; i++) add(0, 1, 1, 1, 0, 2, 0, 0, FBusy);
    add(0, 0, 1, 1, 0, 2, 0, 0, FStep);
    add(0, 0, 1, 1, 4, 2, 0, 0, FId);
    add(0, 0, 1, 1, 0, 0, 1, 0, FStep);
    add(0, 0, 1, 1, 4, 0, 1, 0, FStep);
    add(0, 0, 1, 1, 0, 2, 1, 0, FStep);
    add(0, 0, 1, 1, 4, 2, 1, 0, FOpc);
    // Test 3: pch_avail low for 2 cycles -> WAIT, then one WAIT->RUN cycle
    add(1, 0, 1, 1, 0, 0, 0, 0, FIdle);
    add(0, 0, 1, 1, 0, 0, 0, 0, FStep);
    add(0, 0, 1, 1, 4, 0, 0, 0, FStep);
    add(0, 0, 0, 1, 0, 2, 0, 0, FBusy);
    add(0, 0, 0, 1, 0, 2, 0, 0, FBusy);
    add(0, 0, 1, 1, 0, 2, 0, 0, FBusy);
    add(0, 0, 1, 1, 0, 2, 0, 0, FStep);
    add(0, 0, 1, 1, 4, 2, 0, 0, FId);
    add(0, 0, 1, 1, 0, 0, 1, 0, FStep);
    add(0, 0, 1, 1, 4, 0, 1, 0, FStep);
    add(0, 0, 1, 1, 0, 2, 1, 0, FStep);
    add(0, 0, 1, 1, 4, 2, 1, 0, FOpc);
    // Test 4: 4/2/1/2, two pch entries per id
    cfg(4, 2, 1, 2);
    add(1, 0, 1, 0, 0, 0, 0, 0, FIdle);
    add(0, 0, 1, 0, 0, 0, 0, 0, FPch);
    add(0, 0, 1, 1, 0, 0, 0, 0, FRnd);
    add(0, 0, 1, 0, 0, 0, 0, 1, FPch);
    add(0, 0, 1, 1, 0, 0, 0, 1, FOpc);
    // Test 5: all limits zero -> treated as one
    cfg(0, 0, 0, 0);
    add(1, 0, 1, 0, 0, 0, 0, 0, FIdle);
    add(0, 0, 1, 0, 0, 0, 0, 0, FPch);
    add(0, 0, 1, 0, 0, 0, 0, 0, FPch);
    add(0, 0, 1, 1, 0, 0, 0, 0, FOpc);
    add(0, 0, 1, 1, 0, 0, 0, 0, FIdle);

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_qb_counter", 0, 32'(bus.qb_counter), 32'(qb_flat('0)));
    chk("rst_uc_counter", 0, 32'(bus.uc_counter), 32'(uc_flat('0)));
    chk("rst_id", 0, 32'(bus.id_counter), 32'd0);
    chk("rst_round", 0, 32'(bus.round_counter), 32'd0);
    chk("rst_flags", 0, 32'(dut_flags()), 32'(FIdle));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      bus.qb_limit = vecs[i].qbl; bus.uc_limit = vecs[i].ucl;
      bus.id_len = vecs[i].idl; bus.round_len = vecs[i].rl;
      bus.start = vecs[i].start; bus.stall = vecs[i].stall;
      bus.pch_avail = vecs[i].avail; bus.pch_last = vecs[i].last;
      #1;
      chk("qb_counter", i, 32'(bus.qb_counter), 32'(qb_flat(vecs[i].qb0)));
      chk("uc_counter", i, 32'(bus.uc_counter), 32'(uc_flat(vecs[i].uc0)));
      chk("id_counter", i, 32'(bus.id_counter), 32'(vecs[i].id));
      chk("round_counter", i, 32'(bus.round_counter), 32'(vecs[i].rnd));
      chk("flags", i, 32'(dut_flags()), 32'(vecs[i].flags));
    end

    // Test 6: reset on the final step of a sweep (id_counter = 1)
    @(negedge clk);
    bus.qb_limit = 5'd8; bus.uc_limit = 3'd4; bus.id_len = 4'd2; bus.round_len = 3'd1;
    bus.start = 1'b1; bus.stall = 1'b0; bus.pch_avail = 1'b1; bus.pch_last = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
    #1;
    chk("pre_rst_id", 100, 32'(bus.id_counter), 32'd1);
    chk("pre_rst_opcode", 100, 32'(bus.next_opcode), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_cycle_strobes", 101, 32'(dut_flags() & 6'b011111), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.start = 1'b1;
    #1;
    chk("post_rst_qb", 102, 32'(bus.qb_counter), 32'(qb_flat('0)));
    chk("post_rst_uc", 102, 32'(bus.uc_counter), 32'(uc_flat('0)));
    chk("post_rst_id", 102, 32'(bus.id_counter), 32'd0);
    chk("post_rst_flags", 102, 32'(dut_flags()), 32'(FIdle));
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    chk("restart_flags", 103, 32'(dut_flags()), 32'(FStep));
    cyc = 0;
    while (bus.next_opcode !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    chk("steps_to_opcode", 104, 32'(cyc), 32'd7);
    @(negedge clk);
    #1;
    chk("final_busy", 105, 32'(bus.busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
